cpu: RTL and testbench

- Five-stage in-order pipelined RV32 subset core (IF, ID, EX, MEM, WB).
- Internal instruction memory, data memory and register file.
- Top-level integration block; the bench preloads the memories and register file hierarchically, then observes PC, registers, data memory and hazard counters each cycle.

---
 rtl/cpu.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cpu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu                                                          |
// | Description : Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB) with  |
// |               internal instruction memory, data memory and register file.  |
// | Ports       : clk_i   - system clock, rising edge                          |
// |               rst_i   - asynchronous active-low reset                      |
// |               start_i - run enable; PC holds while low                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package cpu_pkg;
   localparam logic [2:0] c_alu_add = 3'd0;
   localparam logic [2:0] c_alu_sub = 3'd1;
   localparam logic [2:0] c_alu_mul = 3'd2;
   localparam logic [2:0] c_alu_and = 3'd3;
   localparam logic [2:0] c_alu_xor = 3'd4;
   localparam logic [2:0] c_alu_sll = 3'd5;
   localparam logic [2:0] c_alu_sra = 3'd6;
endpackage

// Program counter register.
module cpu_pc (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [31:0] next_i,
   output logic [31:0] pc_o
);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   pc_o <= '0;
      else if (we_i) pc_o <= next_i;
   end
endmodule

// Word-addressed instruction ROM, loaded externally.
module cpu_imem #(parameter int WORDS = 256, parameter int AW = $clog2(WORDS)) (
   input  logic [AW-1:0] addr_i,
   output logic [31:0]   instr_o
);
   logic [31:0] memory [0:WORDS-1];
   assign instr_o = memory[addr_i];
endmodule

// Data memory: combinational read, synchronous write.
module cpu_dmem #(parameter int WORDS = 32, parameter int AW = $clog2(WORDS)) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] memory [0:WORDS-1];
   always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i] <= wdata_i;
   end
   assign rdata_o = memory[addr_i];
endmodule

// Register file; a read of the register being written this cycle sees the new value.
module cpu_regfile (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o
);
   logic [31:0] register [0:31];
   always_ff @(posedge clk_i) begin
      if (we_i && rd_i != 5'd0) register[rd_i] <= wd_i;
   end
   assign rd1_o = (rs1_i == 5'd0) ? '0 : (we_i && rd_i == rs1_i) ? wd_i : register[rs1_i];
   assign rd2_o = (rs2_i == 5'd0) ? '0 : (we_i && rd_i == rs2_i) ? wd_i : register[rs2_i];
endmodule

// Load-use detector: a load in EX feeding the instruction in ID.
module cpu_hazard (
   input  logic       idex_mem_read_i,
   input  logic [4:0] idex_rd_i,
   input  logic [4:0] ifid_rs1_i,
   input  logic [4:0] ifid_rs2_i,
   output logic       STALL
);
   assign STALL = idex_mem_read_i && (idex_rd_i != 5'd0) &&
                  ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
endmodule

// Main decoder and immediate generator. Unknown encodings decode to a NOP.
module cpu_control (
   input  logic [31:0] instr_i,
   output logic        RegWrite_o,
   output logic        MemRead_o,
   output logic        MemWrite_o,
   output logic        MemToReg_o,
   output logic        ALUSrc_o,
   output logic        Branch_o,
   output logic [2:0]  ALUOp_o,
   output logic [31:0] imm_o
);
   import cpu_pkg::*;
   logic [6:0] w_op, w_f7;
   logic [2:0] w_f3;
   logic       w_unused_rs;
   assign w_op        = instr_i[6:0];
   assign w_f3        = instr_i[14:12];
   assign w_f7        = instr_i[31:25];
   assign w_unused_rs = ^instr_i[19:15];

   always_comb begin
      RegWrite_o = 1'b0; MemRead_o = 1'b0; MemWrite_o = 1'b0; MemToReg_o = 1'b0;
      ALUSrc_o   = 1'b0; Branch_o  = 1'b0; ALUOp_o    = c_alu_add;
      imm_o      = {{20{instr_i[31]}}, instr_i[31:20]};
      case (w_op)
         7'b0110011: begin
            RegWrite_o = 1'b1;
            case ({w_f7, w_f3})
               10'b0000000_000: ALUOp_o = c_alu_add;
               10'b0100000_000: ALUOp_o = c_alu_sub;
               10'b0000001_000: ALUOp_o = c_alu_mul;
               10'b0000000_111: ALUOp_o = c_alu_and;
               10'b0000000_100: ALUOp_o = c_alu_xor;
               10'b0000000_001: ALUOp_o = c_alu_sll;
               default:         RegWrite_o = 1'b0;
            endcase
         end
         7'b0010011: begin
            if (w_f3 == 3'b000) begin
               RegWrite_o = 1'b1; ALUSrc_o = 1'b1;
            end else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) begin
               RegWrite_o = 1'b1; ALUSrc_o = 1'b1; ALUOp_o = c_alu_sra;
            end
         end
         7'b0000011: if (w_f3 == 3'b010) begin
            RegWrite_o = 1'b1; MemRead_o = 1'b1; MemToReg_o = 1'b1; ALUSrc_o = 1'b1;
         end
         7'b0100011: if (w_f3 == 3'b010) begin
            MemWrite_o = 1'b1; ALUSrc_o = 1'b1;
            imm_o      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         7'b1100011: if (w_f3 == 3'b000) begin
            Branch_o = 1'b1;
            imm_o    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
         end
         default: ;
      endcase
   end
endmodule

// beq resolution in ID. Held off during a stall because the operands are not ready.
module cpu_branch (
   input  logic        branch_i,
   input  logic        stall_i,
   input  logic [31:0] rd1_i,
   input  logic [31:0] rd2_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] imm_i,
   output logic        FLUSH,
   output logic [31:0] target_o
);
   assign FLUSH    = branch_i && !stall_i && (rd1_i == rd2_i);
   assign target_o = pc_i + imm_i;
endmodule

module cpu #(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i
);
   import cpu_pkg::*;
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] w_pc, w_instr, w_target, w_imm, w_rd1, w_rd2, w_rdata, w_wb_data;
   logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu;
   logic        w_stall, w_flush, w_branch;
   logic        w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src;
   logic [2:0]  w_alu_op;

   logic [31:0] r_ifid_pc, r_ifid_instr;
   logic        r_idex_reg_write, r_idex_mem_read, r_idex_mem_write, r_idex_mem_to_reg, r_idex_alu_src;
   logic [2:0]  r_idex_alu_op;
   logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;
   logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
   logic        r_exmem_reg_write, r_exmem_mem_write, r_exmem_mem_to_reg;
   logic [31:0] r_exmem_alu, r_exmem_store;
   logic [4:0]  r_exmem_rd;
   logic        r_memwb_reg_write, r_memwb_mem_to_reg;
   logic [31:0] r_memwb_alu, r_memwb_rdata;
   logic [4:0]  r_memwb_rd;

   cpu_pc PC (.clk_i(clk_i), .rst_ni(rst_i), .we_i(start_i && !w_stall),
              .next_i(w_flush ? w_target : w_pc + 32'd4), .pc_o(w_pc));

   cpu_imem #(.WORDS(IMEM_WORDS)) Instruction_Memory (.addr_i(w_pc[IAW+1:2]), .instr_o(w_instr));

   cpu_regfile Registers (.clk_i(clk_i), .we_i(r_memwb_reg_write), .rd_i(r_memwb_rd),
                          .wd_i(w_wb_data), .rs1_i(r_ifid_instr[19:15]),
                          .rs2_i(r_ifid_instr[24:20]), .rd1_o(w_rd1), .rd2_o(w_rd2));

   cpu_control Control (.instr_i(r_ifid_instr), .RegWrite_o(w_reg_write), .MemRead_o(w_mem_read),
                        .MemWrite_o(w_mem_write), .MemToReg_o(w_mem_to_reg), .ALUSrc_o(w_alu_src),
                        .Branch_o(w_branch), .ALUOp_o(w_alu_op), .imm_o(w_imm));

   cpu_hazard Hazard_Detection_Unit (.idex_mem_read_i(r_idex_mem_read), .idex_rd_i(r_idex_rd),
                                     .ifid_rs1_i(r_ifid_instr[19:15]),
                                     .ifid_rs2_i(r_ifid_instr[24:20]), .STALL(w_stall));

   cpu_branch Branch_Unit (.branch_i(w_branch), .stall_i(w_stall), .rd1_i(w_rd1), .rd2_i(w_rd2),
                           .pc_i(r_ifid_pc), .imm_i(w_imm), .FLUSH(w_flush), .target_o(w_target));

   cpu_dmem #(.WORDS(DMEM_WORDS)) Data_Memory (.clk_i(clk_i), .we_i(r_exmem_mem_write),
                                                .addr_i(r_exmem_alu[DAW+1:2]),
                                                .wdata_i(r_exmem_store), .rdata_o(w_rdata));

   assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_rdata : r_memwb_alu;

   // EX operand forwarding: the younger result in EX/MEM wins over MEM/WB.
   always_comb begin
      w_fwd_a = r_idex_rd1;
      if (r_exmem_reg_write && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs1)      w_fwd_a = r_exmem_alu;
      else if (r_memwb_reg_write && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs1) w_fwd_a = w_wb_data;
      w_fwd_b = r_idex_rd2;
      if (r_exmem_reg_write && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs2)      w_fwd_b = r_exmem_alu;
      else if (r_memwb_reg_write && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs2) w_fwd_b = w_wb_data;
      w_alu_b = r_idex_alu_src ? r_idex_imm : w_fwd_b;
      case (r_idex_alu_op)
         c_alu_sub: w_alu = w_fwd_a - w_alu_b;
         c_alu_mul: w_alu = w_fwd_a * w_alu_b;
         c_alu_and: w_alu = w_fwd_a & w_alu_b;
         c_alu_xor: w_alu = w_fwd_a ^ w_alu_b;
         c_alu_sll: w_alu = w_fwd_a << w_alu_b[4:0];
         c_alu_sra: w_alu = $signed(w_fwd_a) >>> w_alu_b[4:0];
         default:   w_alu = w_fwd_a + w_alu_b;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ifid_pc <= '0; r_ifid_instr <= '0;
         r_idex_reg_write <= 1'b0; r_idex_mem_read <= 1'b0; r_idex_mem_write <= 1'b0;
         r_idex_mem_to_reg <= 1'b0; r_idex_alu_src <= 1'b0; r_idex_alu_op <= c_alu_add;
         r_idex_rd1 <= '0; r_idex_rd2 <= '0; r_idex_imm <= '0;
         r_idex_rs1 <= '0; r_idex_rs2 <= '0; r_idex_rd <= '0;
         r_exmem_reg_write <= 1'b0; r_exmem_mem_write <= 1'b0; r_exmem_mem_to_reg <= 1'b0;
         r_exmem_alu <= '0; r_exmem_store <= '0; r_exmem_rd <= '0;
         r_memwb_reg_write <= 1'b0; r_memwb_mem_to_reg <= 1'b0;
         r_memwb_alu <= '0; r_memwb_rdata <= '0; r_memwb_rd <= '0;
      end else begin
         // IF/ID: a taken branch squashes the wrong-path fetch; while idle a bubble
         // enters so the held PC is not issued repeatedly.
         if (w_flush) begin
            r_ifid_pc <= '0; r_ifid_instr <= '0;
         end else if (!w_stall) begin
            r_ifid_pc    <= start_i ? w_pc    : '0;
            r_ifid_instr <= start_i ? w_instr : '0;
         end
         // ID/EX: a stall turns the stalled instruction's EX slot into a bubble.
         r_idex_reg_write  <= w_reg_write  && !w_stall;
         r_idex_mem_read   <= w_mem_read   && !w_stall;
         r_idex_mem_write  <= w_mem_write  && !w_stall;
         r_idex_mem_to_reg <= w_mem_to_reg && !w_stall;
         r_idex_alu_src    <= w_alu_src    && !w_stall;
         r_idex_alu_op     <= w_stall ? c_alu_add : w_alu_op;
         r_idex_rd         <= w_stall ? 5'd0 : r_ifid_instr[11:7];
         r_idex_rd1 <= w_rd1; r_idex_rd2 <= w_rd2; r_idex_imm <= w_imm;
         r_idex_rs1 <= r_ifid_instr[19:15]; r_idex_rs2 <= r_ifid_instr[24:20];
         // EX/MEM
         r_exmem_reg_write <= r_idex_reg_write; r_exmem_mem_write <= r_idex_mem_write;
         r_exmem_mem_to_reg <= r_idex_mem_to_reg;
         r_exmem_alu <= w_alu; r_exmem_store <= w_fwd_b; r_exmem_rd <= r_idex_rd;
         // MEM/WB
         r_memwb_reg_write <= r_exmem_reg_write; r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
         r_memwb_alu <= r_exmem_alu; r_memwb_rdata <= w_rdata; r_memwb_rd <= r_exmem_rd;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu                                                       |
// | Description : Self-checking bench for cpu. Programs are preloaded through  |
// |               the hierarchy; expected architectural results are queued     |
// |               when a program is set up and compared after it has run.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu;
   logic clk_i;
   logic rst_i;
   logic start_i;

   cpu #(.IMEM_WORDS(256), .DMEM_WORDS(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct { bit is_mem; int idx; logic [31:0] val; } exp_t;
   exp_t        sb[$];
   logic [31:0] pc_q[$];
   logic [31:0] prog[$];
   logic [31:0] dinit [0:31];
   int          checks = 0;
   int          errors = 0;
   int          stall_cnt, flush_cnt, branch_cnt;

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      logic [6:0] a = f7[6:0]; logic [4:0] b = rs2[4:0]; logic [4:0] c = rs1[4:0];
      logic [2:0] d = f3[2:0]; logic [4:0] e = rd[4:0];
      return {a, b, c, d, e, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input int op);
      logic [11:0] a = imm[11:0]; logic [4:0] c = rs1[4:0]; logic [2:0] d = f3[2:0];
      logic [4:0] e = rd[4:0]; logic [6:0] o = op[6:0];
      return {a, c, d, e, o};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [11:0] a = imm[11:0]; logic [4:0] b = rs2[4:0]; logic [4:0] c = rs1[4:0];
      return {a[11:5], b, c, 3'b010, a[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1);
      logic [12:0] a = off[12:0]; logic [4:0] b = rs2[4:0]; logic [4:0] c = rs1[4:0];
      return {a[12], a[10:5], b, c, 3'b000, a[4:1], a[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, 7'b0010011);
   endfunction

   function automatic exp_t mk(input bit is_mem, input int idx, input logic [31:0] val);
      exp_t e;
      e.is_mem = is_mem; e.idx = idx; e.val = val;
      return e;
   endfunction

   // Hold reset, load program/data, clear registers, then release with start_i high.
   task automatic start_prog();
      @(negedge clk_i);
      rst_i = 1'b0; start_i = 1'b0;
      #1;
      for (int i = 0; i < 256; i++)
         dut.Instruction_Memory.memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
      for (int i = 0; i < 32; i++) begin
         dut.Registers.register[i]   = 32'h0;
         dut.Data_Memory.memory[i]   = dinit[i];
      end
      @(negedge clk_i);
      rst_i = 1'b1; start_i = 1'b1;
      stall_cnt = 0; flush_cnt = 0; branch_cnt = 0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (dut.Hazard_Detection_Unit.STALL === 1'b1) stall_cnt++;
         if (dut.Branch_Unit.FLUSH === 1'b1)           flush_cnt++;
         if (dut.Control.Branch_o === 1'b1)            branch_cnt++;
      end
   endtask

   task automatic clear_setup();
      prog.delete();
      sb.delete();
      for (int i = 0; i < 32; i++) dinit[i] = 32'h0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      clear_setup();
      start_prog();
      checks++;
      if (dut.PC.pc_o !== 32'h0 || dut.Hazard_Detection_Unit.STALL !== 1'b0 ||
          dut.Branch_Unit.FLUSH !== 1'b0 || dut.Control.Branch_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pc=%h stall=%b flush=%b branch=%b, required pc=0 and all 0",
                  dut.PC.pc_o, dut.Hazard_Detection_Unit.STALL, dut.Branch_Unit.FLUSH,
                  dut.Control.Branch_o);
      end
      for (int k = 0; k < 16; k++) pc_q.push_back(32'(4 * k));
      for (int k = 0; k < 16; k++) begin
         exp_pc = pc_q.pop_front();
         checks++;
         if (dut.PC.pc_o !== exp_pc) begin
            errors++;
            $display("FAIL pc_seq[%0d]: got %h, required %h", k, dut.PC.pc_o, exp_pc);
         end
         step(1);
      end
      start_i = 1'b0;
      step(3);
      checks++;
      if (dut.PC.pc_o !== 32'd64) begin
         errors++;
         $display("FAIL pc_hold: got %h, required %h", dut.PC.pc_o, 32'd64);
      end
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (dut.Registers.register[r] !== 32'h0) begin
            errors++;
            $display("FAIL zero_prog_x%0d: got %h, required 0", r, dut.Registers.register[r]);
         end
      end
      checks++;
      if (stall_cnt != 0 || flush_cnt != 0) begin
         errors++;
         $display("FAIL zero_prog_hazards: stall=%0d flush=%0d, required 0/0", stall_cnt, flush_cnt);
      end
      // Asynchronous reset: PC must clear without a clock edge.
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      checks++;
      if (dut.PC.pc_o !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_pc: got %h, required 0", dut.PC.pc_o);
      end
   endtask

   task automatic test_timing();
      clear_setup();
      prog.push_back(addi(1, 0, 10));
      start_prog();
      step(4);
      checks++;
      if (dut.Registers.register[1] !== 32'h0) begin
         errors++;
         $display("FAIL wb_edge4_x1: got %h, required 0", dut.Registers.register[1]);
      end
      step(1);
      checks++;
      if (dut.Registers.register[1] !== 32'd10) begin
         errors++;
         $display("FAIL wb_edge5_x1: got %h, required %h", dut.Registers.register[1], 32'd10);
      end
   endtask

   task automatic test_forwarding();
      exp_t e; logic [31:0] got;
      clear_setup();
      prog.push_back(addi(1, 0, 10));
      prog.push_back(addi(2, 0, 3));
      prog.push_back(enc_r(7'b0100000, 2, 1, 0, 3));
      prog.push_back(enc_r(7'b0000001, 2, 3, 0, 4));
      sb.push_back(mk(0, 1, 32'd10)); sb.push_back(mk(0, 2, 32'd3));
      sb.push_back(mk(0, 3, 32'd7));  sb.push_back(mk(0, 4, 32'd21));
      start_prog();
      step(12);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = e.is_mem ? dut.Data_Memory.memory[e.idx] : dut.Registers.register[e.idx];
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL fwd_%s%0d: got %h, required %h", e.is_mem ? "mem" : "x", e.idx, got, e.val);
         end
      end
      checks++;
      if (stall_cnt != 0 || flush_cnt != 0) begin
         errors++;
         $display("FAIL fwd_hazards: stall=%0d flush=%0d, required 0/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_load_use();
      exp_t e; logic [31:0] got;
      clear_setup();
      dinit[0] = 32'd5;
      prog.push_back(enc_i(0, 0, 3'b010, 5, 7'b0000011));
      prog.push_back(enc_r(0, 5, 5, 0, 6));
      sb.push_back(mk(0, 5, 32'd5)); sb.push_back(mk(0, 6, 32'd10));
      start_prog();
      step(12);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = e.is_mem ? dut.Data_Memory.memory[e.idx] : dut.Registers.register[e.idx];
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL loaduse_%s%0d: got %h, required %h", e.is_mem ? "mem" : "x", e.idx, got, e.val);
         end
      end
      checks++;
      if (stall_cnt != 1) begin
         errors++;
         $display("FAIL loaduse_stall_cycles: got %0d, required 1", stall_cnt);
      end
   endtask

   task automatic test_alu_ops();
      exp_t e; logic [31:0] got;
      clear_setup();
      prog.push_back(addi(2, 0, 3));
      prog.push_back(addi(7, 0, -8));
      prog.push_back(enc_i(12'h402, 7, 3'b101, 8, 7'b0010011));   // srai x8,x7,2
      prog.push_back(enc_r(0, 2, 2, 3'b001, 9));                   // sll  x9,x2,x2
      prog.push_back(enc_r(0, 2, 7, 3'b100, 10));                  // xor  x10,x7,x2
      prog.push_back(enc_r(0, 7, 9, 3'b111, 11));                  // and  x11,x9,x7
      prog.push_back(enc_r(7'b0100000, 7, 2, 0, 12));              // sub  x12,x2,x7
      prog.push_back(32'hFFFF_FFFF);                               // unknown opcode
      prog.push_back(enc_r(0, 2, 7, 3'b110, 13));                  // or: not supported
      prog.push_back(enc_i(12'h002, 7, 3'b101, 14, 7'b0010011));   // srli: not supported
      prog.push_back(addi(0, 0, 5));                               // write to x0
      sb.push_back(mk(0, 8, 32'hFFFF_FFFE));  sb.push_back(mk(0, 9, 32'd24));
      sb.push_back(mk(0, 10, 32'hFFFF_FFFB)); sb.push_back(mk(0, 11, 32'd24));
      sb.push_back(mk(0, 12, 32'd11));        sb.push_back(mk(0, 31, 32'h0));
      sb.push_back(mk(0, 13, 32'h0));         sb.push_back(mk(0, 14, 32'h0));
      sb.push_back(mk(0, 0, 32'h0));
      start_prog();
      step(20);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = e.is_mem ? dut.Data_Memory.memory[e.idx] : dut.Registers.register[e.idx];
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL alu_%s%0d: got %h, required %h", e.is_mem ? "mem" : "x", e.idx, got, e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; logic [31:0] got;
      clear_setup();
      prog.push_back(addi(10, 0, 42));
      prog.push_back(enc_s(8, 10, 0));                         // sw  x10,8(x0)
      prog.push_back(enc_i(8, 0, 3'b010, 11, 7'b0000011));     // lw  x11,8(x0)
      prog.push_back(enc_r(0, 10, 11, 0, 12));                 // add x12,x11,x10
      sb.push_back(mk(1, 2, 32'd42)); sb.push_back(mk(0, 11, 32'd42));
      sb.push_back(mk(0, 12, 32'd84));
      start_prog();
      step(14);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = e.is_mem ? dut.Data_Memory.memory[e.idx] : dut.Registers.register[e.idx];
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL ldst_%s%0d: got %h, required %h", e.is_mem ? "mem" : "x", e.idx, got, e.val);
         end
      end
      checks++;
      if (stall_cnt != 1) begin
         errors++;
         $display("FAIL ldst_stall_cycles: got %0d, required 1", stall_cnt);
      end
   endtask

   // Countdown loop. Two NOPs separate the decrement from the beq so that
   // the compared register comes from writeback rather than EX/MEM.
   task automatic test_branch_loop();
      exp_t e; logic [31:0] got;
      clear_setup();
      prog.push_back(addi(1, 0, 3));       //  0
      prog.push_back(addi(1, 1, -1));      //  4 loop
      prog.push_back(32'h0);               //  8
      prog.push_back(32'h0);               // 12
      prog.push_back(enc_b(12, 0, 1));     // 16 beq x1,x0,exit(28)
      prog.push_back(enc_b(-16, 0, 0));    // 20 beq x0,x0,loop(4)
      prog.push_back(addi(20, 0, 99));     // 24 wrong path
      prog.push_back(addi(21, 0, 7));      // 28 exit
      sb.push_back(mk(0, 1, 32'h0)); sb.push_back(mk(0, 20, 32'h0));
      sb.push_back(mk(0, 21, 32'd7));
      start_prog();
      step(60);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = e.is_mem ? dut.Data_Memory.memory[e.idx] : dut.Registers.register[e.idx];
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL loop_%s%0d: got %h, required %h", e.is_mem ? "mem" : "x", e.idx, got, e.val);
         end
      end
      checks++;
      if (flush_cnt != 3) begin
         errors++;
         $display("FAIL loop_flush_cycles: got %0d, required 3", flush_cnt);
      end
      checks++;
      if (branch_cnt != 5) begin
         errors++;
         $display("FAIL loop_branch_decode_cycles: got %0d, required 5", branch_cnt);
      end
      checks++;
      if (stall_cnt != 0) begin
         errors++;
         $display("FAIL loop_stall_cycles: got %0d, required 0", stall_cnt);
      end
   endtask

   initial begin
      rst_i   = 1'b0;
      start_i = 1'b0;
      test_reset();
      test_timing();
      test_forwarding();
      test_load_use();
      test_alu_ops();
      test_back_to_back();
      test_branch_loop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
